// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : ID-stage stall logic using a per-register latency countdown
//            scoreboard with RAW/WAW detection and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int MAX_LAT  = 3,
    parameter int LAT_W    = 2,
    parameter int CNT_W    = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] i_src_addr,
    input  logic [NUM_SRC-1:0]        i_src_used,
    input  logic [ADDR_W-1:0]         i_rd_addr,
    input  logic                      i_rd_wren,
    input  logic [LAT_W-1:0]          i_lat,
    input  logic                      i_hold,
    input  logic                      i_flush,
    output logic                      o_stall_from_ID,
    output logic                      o_issue,
    output logic [NUM_SRC-1:0]        o_stall_src,
    output logic                      o_stall_waw,
    output logic [NUM_REGS-1:0]       o_busy_mask,
    output logic [CNT_W-1:0]          o_stall_cnt
);

    localparam logic [LAT_W-1:0] c_max_lat = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [LAT_W-1:0] w_lat;
    logic             w_rd_nz;

    assign w_lat   = (i_lat > c_max_lat) ? c_max_lat : i_lat;
    assign w_rd_nz = (i_rd_addr != '0);

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            logic [ADDR_W-1:0] w_src;
            assign w_src          = i_src_addr[k*ADDR_W +: ADDR_W];
            assign o_stall_src[k] = i_id_valid & i_src_used[k] & (w_src != '0)
                                  & (cnt_q[w_src] != '0);
        end
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
            assign o_busy_mask[r] = (cnt_q[r] != '0);
        end
    endgenerate

    // Only a strictly longer pending write blocks; equal or shorter older
    // writes are guaranteed to retire first.
    assign o_stall_waw     = i_id_valid & i_rd_wren & w_rd_nz & (cnt_q[i_rd_addr] > w_lat);
    assign o_stall_from_ID = ((|o_stall_src) | o_stall_waw) & ~i_flush;
    assign o_issue         = i_id_valid & ~o_stall_from_ID & ~i_hold & ~i_flush;
    assign o_stall_cnt     = stall_cnt_q;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!i_hold && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
        if (o_issue && i_rd_wren && w_rd_nz && w_lat != '0) begin
            cnt_d[i_rd_addr] = w_lat;
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall_from_ID && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed and randomized bench for hazard_scoreboard against a
//            countdown reference model of the stall rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NR    = 32;
    localparam int AW    = 5;
    localparam int NS    = 2;
    localparam int LW    = 2;
    localparam int CW    = 4;
    localparam int SATV  = 15;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_id_valid;
    logic [NS*AW-1:0]  i_src_addr;
    logic [NS-1:0]     i_src_used;
    logic [AW-1:0]     i_rd_addr;
    logic              i_rd_wren;
    logic [LW-1:0]     i_lat;
    logic              i_hold;
    logic              i_flush;
    logic              o_stall_from_ID;
    logic              o_issue;
    logic [NS-1:0]     o_stall_src;
    logic              o_stall_waw;
    logic [NR-1:0]     o_busy_mask;
    logic [CW-1:0]     o_stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    int pend [NR];
    int scnt;

    hazard_scoreboard #(
        .NUM_REGS(NR), .ADDR_W(AW), .NUM_SRC(NS), .MAX_LAT(3), .LAT_W(LW), .CNT_W(CW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid),
        .i_src_addr(i_src_addr), .i_src_used(i_src_used), .i_rd_addr(i_rd_addr),
        .i_rd_wren(i_rd_wren), .i_lat(i_lat), .i_hold(i_hold), .i_flush(i_flush),
        .o_stall_from_ID(o_stall_from_ID), .o_issue(o_issue), .o_stall_src(o_stall_src),
        .o_stall_waw(o_stall_waw), .o_busy_mask(o_busy_mask), .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_busy();
        logic [NR-1:0] m = '0;
        for (int r = 1; r < NR; r++) m[r] = (pend[r] != 0);
        return m;
    endfunction

    // Drive one ID cycle in the low phase, check against the model, clock it.
    task automatic step(input logic v, input int s0, input int s1, input logic [1:0] used,
                        input int rd, input logic wr, input int lat,
                        input logic hold, input logic flush);
        logic [1:0] e_src;
        logic       e_waw, e_stall, e_issue;
        int         l;
        i_id_valid = v;
        i_src_addr = {AW'(s1), AW'(s0)};
        i_src_used = used;
        i_rd_addr  = AW'(rd);
        i_rd_wren  = wr;
        i_lat      = LW'(lat);
        i_hold     = hold;
        i_flush    = flush;
        l = (lat > 3) ? 3 : lat;
        e_src[0] = v && used[0] && s0 != 0 && pend[s0] != 0;
        e_src[1] = v && used[1] && s1 != 0 && pend[s1] != 0;
        e_waw    = v && wr && rd != 0 && pend[rd] > l;
        e_stall  = ((|e_src) || e_waw) && !flush;
        e_issue  = v && !e_stall && !hold && !flush;
        #1;
        check("stall_src",  32'(o_stall_src),     32'(e_src));
        check("stall_waw",  32'(o_stall_waw),     32'(e_waw));
        check("stall_id",   32'(o_stall_from_ID), 32'(e_stall));
        check("issue",      32'(o_issue),         32'(e_issue));
        check("busy_mask",  o_busy_mask,          model_busy());
        check("stall_cnt",  32'(o_stall_cnt),     32'(scnt));
        @(posedge i_clk);
        if (e_stall && scnt < SATV) scnt++;
        if (!hold) begin
            for (int r = 1; r < NR; r++) if (pend[r] > 0) pend[r]--;
        end
        if (e_issue && wr && rd != 0 && l != 0) pend[rd] = l;
        @(negedge i_clk);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 2'b00, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Reset pulse inside the low phase; its effect must be visible before any edge.
    task automatic async_reset();
        #1 i_rst_n = 1'b0;
        #1;
        for (int r = 0; r < NR; r++) pend[r] = 0;
        scnt = 0;
        check("rst_busy", o_busy_mask, '0);
        check("rst_scnt", 32'(o_stall_cnt), 32'd0);
        i_rst_n = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) pend[r] = 0;
        scnt       = 0;
        i_rst_n    = 1'b0;
        i_id_valid = 1'b0; i_src_addr = '0; i_src_used = '0; i_rd_addr = '0;
        i_rd_wren  = 1'b0; i_lat = '0; i_hold = 1'b0; i_flush = 1'b0;
        repeat (2) @(negedge i_clk);
        check("reset_stall", 32'(o_stall_from_ID), 32'd0);
        check("reset_issue", 32'(o_issue), 32'd0);
        check("reset_busy",  o_busy_mask, '0);
        check("reset_cnt",   32'(o_stall_cnt), 32'd0);
        i_rst_n = 1'b1;

        // Load-use with latency 1
        step(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
        step(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
        check("t1_scnt", 32'(o_stall_cnt), 32'd1);

        // Forwarded ALU result never marks the register busy
        step(1, 0, 0, 2'b00, 7, 1, 0, 0, 0);
        check("t2_busy_a", o_busy_mask, '0);
        step(1, 0, 7, 2'b10, 0, 0, 0, 0, 0);
        check("t2_busy_b", o_busy_mask, '0);

        // Register 0 ignored; hold freezes the countdown
        step(1, 0, 0, 2'b00, 0, 1, 3, 0, 0);
        check("t3_r0_busy", o_busy_mask, '0);
        step(1, 0, 0, 2'b00, 9, 1, 2, 0, 0);
        repeat (3) step(1, 9, 0, 2'b01, 0, 0, 0, 1, 0);
        check("t3_hold_busy", o_busy_mask, 32'h0000_0200);
        step(1, 9, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 9, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 9, 0, 2'b01, 0, 0, 0, 0, 0);
        check("t3_scnt", 32'(o_stall_cnt), 32'd6);

        // WAW: short write waits until the long one has at most 1 cycle left
        step(1, 0, 0, 2'b00, 4, 1, 3, 0, 0);
        repeat (3) step(1, 0, 0, 2'b00, 4, 1, 1, 0, 0);
        check("t4_busy", o_busy_mask, 32'h0000_0010);
        check("t4_scnt", 32'(o_stall_cnt), 32'd8);

        // Flush beats stall; scoreboard keeps counting
        step(1, 0, 0, 2'b00, 6, 1, 3, 0, 0);
        step(1, 6, 0, 2'b01, 0, 0, 0, 0, 1);
        check("t5_scnt", 32'(o_stall_cnt), 32'd8);
        check("t5_busy", o_busy_mask, 32'h0000_0040);

        // Mid-operation reset, then saturation of the stall counter
        step(1, 0, 0, 2'b00, 10, 1, 3, 0, 0);
        step(1, 0, 0, 2'b00, 11, 1, 3, 0, 0);
        step(1, 0, 0, 2'b00, 12, 1, 3, 0, 0);
        async_reset();
        idle();
        step(1, 0, 0, 2'b00, 13, 1, 3, 0, 0);
        repeat (20) step(1, 13, 13, 2'b11, 0, 0, 0, 1, 0);
        check("t6_sat", 32'(o_stall_cnt), 32'd15);
        step(1, 13, 0, 2'b01, 0, 0, 0, 0, 0);
        check("t6_sat_hold", 32'(o_stall_cnt), 32'd15);

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) async_reset();
            step($urandom_range(0, 7) != 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
